// File: rtl/box_cmd_seq.sv
// box_cmd_seq: FIFO-buffered read/write command sequencer driving the 4-entry register box.
// Define BOX_SEQ_RDBACK_EN to read back and verify every write before responding.
module box_cmd_seq #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              box_read_enable,
  output logic              box_write_enable,
  output logic [DATA_W-1:0] box_write_data,
  output logic [ADDR_W-1:0] box_address,
  input  logic [DATA_W-1:0] box_read_data,
  input  logic              box_read_active,
  output logic              busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 1 + ADDR_W + DATA_W;
  localparam int TW = $clog2(TIMEOUT + 1);
`ifdef BOX_SEQ_RDBACK_EN
  typedef enum logic [2:0] {IDLE, WRITE, READ_WAIT, VERIFY, RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, WRITE, READ_WAIT, RESP} state_t;
`endif
  state_t state;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic [TW-1:0] tcnt;
  logic push, pop, chk;
  logic [EW-1:0] head;
  assign cmd_ready = count != (PW+1)'(FIFO_DEPTH);
  assign push = cmd_valid && cmd_ready;
  assign pop = state == IDLE && count != '0;
  assign head = mem[rd_ptr];
  assign busy = count != '0 || state != IDLE;
`ifdef BOX_SEQ_RDBACK_EN
  assign chk = state == VERIFY;
`else
  assign chk = 1'b0;
`endif
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      tcnt <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      box_read_enable <= 1'b0;
      box_write_enable <= 1'b0;
      box_write_data <= '0;
      box_address <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      case (state)
        IDLE: if (pop) begin
          box_address <= head[DATA_W +: ADDR_W];
          tcnt <= '0;
          if (head[EW-1]) begin
            box_write_enable <= 1'b1;
            box_write_data <= head[DATA_W-1:0];
            state <= WRITE;
          end else begin
            box_read_enable <= 1'b1;
            state <= READ_WAIT;
          end
        end
        WRITE: begin
          box_write_enable <= 1'b0;
`ifdef BOX_SEQ_RDBACK_EN
          box_read_enable <= 1'b1;
          tcnt <= '0;
          state <= VERIFY;
`else
          rsp_data <= box_write_data;
          rsp_err <= 1'b0;
          rsp_valid <= 1'b1;
          state <= RESP;
`endif
        end
`ifdef BOX_SEQ_RDBACK_EN
        READ_WAIT, VERIFY: begin
`else
        READ_WAIT: begin
`endif
          if (box_read_active) begin
            rsp_data <= box_read_data;
            rsp_err <= chk && box_read_data != box_write_data;
            box_read_enable <= 1'b0;
            rsp_valid <= 1'b1;
            state <= RESP;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            rsp_data <= '0;
            rsp_err <= 1'b1;
            box_read_enable <= 1'b0;
            rsp_valid <= 1'b1;
            state <= RESP;
          end else tcnt <= tcnt + 1'b1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_box_cmd_seq.sv
// tb_box_cmd_seq: directed self-checking bench for box_cmd_seq with a small register-box model.
module tb_box_cmd_seq;
  logic clk = 0, rst = 0;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [1:0] cmd_addr = 0;
  logic [7:0] cmd_wdata = 0;
  logic rsp_valid, rsp_ready = 0, rsp_err;
  logic [7:0] rsp_data;
  logic box_read_enable, box_write_enable;
  logic [7:0] box_write_data, box_read_data = 0;
  logic [1:0] box_address;
  logic box_read_active = 0, busy;
  logic tie_off = 0, corrupt = 0;
  logic [7:0] regs [4] = '{default: 8'h00};
  int checks = 0, fails = 0;

  box_cmd_seq dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .box_read_enable(box_read_enable), .box_write_enable(box_write_enable),
    .box_write_data(box_write_data), .box_address(box_address),
    .box_read_data(box_read_data), .box_read_active(box_read_active), .busy(busy)
  );

  always #5 clk = ~clk;

  // box model: read_active pulses one cycle after read_enable rises
  always @(posedge clk) begin
    if (box_write_enable) regs[box_address] <= box_write_data ^ {7'b0, corrupt};
    box_read_active <= !tie_off && box_read_enable && !box_read_active;
    box_read_data <= regs[box_address];
  end

  assert property (@(posedge clk) disable iff (!rst) !(box_read_enable && box_write_enable))
    else $error("FAIL strobe_excl: read_enable and write_enable both 1, required not both");

  task automatic send(input logic w, input logic [1:0] a, input logic [7:0] d);
    int n = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (!cmd_ready) begin fails++; $display("FAIL send: cmd_ready=0, required 1 within 60 cycles"); end
    @(posedge clk); @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic get_rsp(output logic [7:0] d, output logic e, output logic ok);
    int n = 0;
    while (!rsp_valid && n < 60) begin @(negedge clk); n++; end
    ok = rsp_valid; d = rsp_data; e = rsp_err;
    rsp_ready = 1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    logic seen = 0;
    #1;
    checks++;
    if ({rsp_valid, rsp_data, rsp_err, box_read_enable, box_write_enable, box_write_data, box_address, busy} !== '0) begin
      fails++; $display("FAIL reset_outputs: valid=%b data=%h err=%b re=%b we=%b wd=%h a=%h busy=%b, required all 0",
        rsp_valid, rsp_data, rsp_err, box_read_enable, box_write_enable, box_write_data, box_address, busy);
    end
    @(negedge clk); rst = 1;
    tie_off = 1;
    send(0, 2'd1, 8'h00);
    @(negedge clk); @(negedge clk);
    checks++;
    if (box_read_enable !== 1'b1) begin fails++; $display("FAIL reset_pre_re: read_enable=%b, required 1", box_read_enable); end
    #2 rst = 0;
    #1;
    checks++;
    if ({rsp_valid, rsp_err, box_read_enable, box_write_enable, busy} !== '0) begin
      fails++; $display("FAIL reset_mid_read: valid=%b err=%b re=%b we=%b busy=%b, required 0", rsp_valid, rsp_err, box_read_enable, box_write_enable, busy);
    end
    @(negedge clk); rst = 1; tie_off = 0;
    for (int i = 0; i < 25; i++) begin @(negedge clk); if (rsp_valid) seen = 1; end
    checks++;
    if (seen) begin fails++; $display("FAIL reset_no_rsp: rsp_valid seen=1, required 0"); end
  endtask

  task automatic test_write();
    logic [7:0] d; logic e, ok;
    send(1, 2'd0, 8'hAA);
    checks++;
    if (box_write_enable !== 1'b0) begin fails++; $display("FAIL wr_k: write_enable=%b, required 0", box_write_enable); end
    @(negedge clk);
    checks++;
    if ({box_write_enable, box_read_enable, box_address, box_write_data, rsp_valid} !== {1'b1, 1'b0, 2'd0, 8'hAA, 1'b0}) begin
      fails++; $display("FAIL wr_k1: we=%b re=%b a=%h wd=%h valid=%b, required we=1 re=0 a=0 wd=aa valid=0",
        box_write_enable, box_read_enable, box_address, box_write_data, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (box_write_enable !== 1'b0) begin fails++; $display("FAIL wr_k2_we: write_enable=%b, required 0", box_write_enable); end
`ifndef BOX_SEQ_RDBACK_EN
    checks++;
    if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, 8'hAA, 1'b0}) begin
      fails++; $display("FAIL wr_k2_rsp: valid=%b data=%h err=%b, required 1 aa 0", rsp_valid, rsp_data, rsp_err);
    end
`endif
    get_rsp(d, e, ok);
    checks++;
    if (!ok || d !== 8'hAA || e !== 1'b0) begin fails++; $display("FAIL wr_rsp: ok=%b data=%h err=%b, required 1 aa 0", ok, d, e); end
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL wr_done: valid=%b busy=%b, required 0 0", rsp_valid, busy); end
  endtask

  task automatic test_write_read();
    logic [7:0] d; logic e, ok;
    logic [7:0] exp [3];
    exp[0] = 8'h55; exp[1] = 8'hAA; exp[2] = 8'h55;
    send(1, 2'd1, 8'h55);
    send(0, 2'd0, 8'h00);
    send(0, 2'd1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      get_rsp(d, e, ok);
      checks++;
      if (!ok || d !== exp[i] || e !== 1'b0) begin fails++; $display("FAIL wr_rd_%0d: ok=%b data=%h err=%b, required 1 %h 0", i, ok, d, e, exp[i]); end
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] d; logic e, ok;
    logic [7:0] exp [5];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44; exp[4] = 8'h33;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cmd_ready !== 1'b1) begin fails++; $display("FAIL full_ready_%0d: cmd_ready=%b, required 1", i, cmd_ready); end
      cmd_valid = 1; cmd_write = i < 4; cmd_addr = 2'(i < 4 ? i : 2); cmd_wdata = exp[i];
      @(posedge clk); @(negedge clk);
    end
    cmd_valid = 0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL full_state: cmd_ready=%b busy=%b, required 0 1", cmd_ready, busy); end
    for (int i = 0; i < 5; i++) begin
      get_rsp(d, e, ok);
      checks++;
      if (!ok || d !== exp[i] || e !== 1'b0) begin fails++; $display("FAIL drain_%0d: ok=%b data=%h err=%b, required 1 %h 0", i, ok, d, e, exp[i]); end
    end
    send(0, 2'd3, 8'h00);
    get_rsp(d, e, ok);
    checks++;
    if (!ok || d !== 8'h44 || e !== 1'b0) begin fails++; $display("FAIL wrap_rd: ok=%b data=%h err=%b, required 1 44 0", ok, d, e); end
  endtask

  task automatic test_timeout();
    logic [7:0] d; logic e, ok;
    int n = 0, hi = 0;
    tie_off = 1;
    send(0, 2'd2, 8'h00);
    while (!box_read_enable && n < 10) begin @(negedge clk); n++; end
    while (box_read_enable && hi < 40) begin hi++; @(negedge clk); end
    checks++;
    if (hi != 15) begin fails++; $display("FAIL timeout_len: read_enable high %0d cycles, required 15", hi); end
    get_rsp(d, e, ok);
    checks++;
    if (!ok || d !== 8'h00 || e !== 1'b1) begin fails++; $display("FAIL timeout_rsp: ok=%b data=%h err=%b, required 1 00 1", ok, d, e); end
    tie_off = 0;
  endtask

  task automatic test_rdback();
    logic [7:0] d; logic e, ok;
    corrupt = 1;
    send(1, 2'd2, 8'h0F);
    get_rsp(d, e, ok);
    corrupt = 0;
    checks++;
`ifdef BOX_SEQ_RDBACK_EN
    if (!ok || d !== 8'h0E || e !== 1'b1) begin fails++; $display("FAIL rdback: ok=%b data=%h err=%b, required 1 0e 1", ok, d, e); end
`else
    if (!ok || d !== 8'h0F || e !== 1'b0) begin fails++; $display("FAIL rdback: ok=%b data=%h err=%b, required 1 0f 0", ok, d, e); end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_write_read();
    test_fifo_full();
    test_timeout();
    test_rdback();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
